burst_sequencer: RTL and testbench
==================================

Name: burst_sequencer

Overview:
Parametrised successor of the 48 MHz radar synchroniser. Holds real-time commands in an internal queue of CMD_DEPTH entries and waits for system TIME to reach each command's start time. It then generates N repetitions of the blank1 / emit (En_Iz) / blank2 / receive (En_Pr) interval train and drives one-cycle DDS start strobes. It sits between the real-time command register (source of WR_DATA and fields) and the DDS chirp block.

Parameters:
TIME_W, 64, width of system time and start time
CNT_W, 32, width of interval durations (cycles)
NP_W, 16, width of pulse count
CMD_DEPTH, 4, command queue depth (power of 2, >=2)

Ports:
CLK  in  1  system clock (48 MHz)
RESET  in  1  synchronous, active-high reset
TIME  in  TIME_W  current system time (cycles)
WR_DATA  in  1  one-cycle strobe: push the command fields below into the queue
MEM_TIME_START  in  TIME_W  time at which the burst begins
MEM_N_impuls  in  NP_W  number of pulse periods
MEM_TYPE_impulse  in  2  bit0: 1 = coherent (DDS started once per burst), 0 = per-pulse restart; bit1 reserved, ignored
MEM_Interval_Ti  in  CNT_W  emit duration
MEM_Interval_Tp  in  CNT_W  receive duration
MEM_Tblank1  in  CNT_W  blank before emit
MEM_Tblank2  in  CNT_W  blank between emit and receive
ABORT  in  1  cancel the active burst and flush the queue
REQ_COMMAND  out  1  one-cycle request for the next command
DDS_start  out  1  one-cycle DDS start strobe
En_Iz  out  1  emit window
En_Pr  out  1  receive window
BUSY  out  1  burst active (any state other than IDLE or WAIT)
LATE  out  1  one-cycle flag: command dropped because its start time had passed
CMD_FULL  out  1  queue full
PULSE_CNT  out  NP_W  index of the current pulse period, 0-based

Behaviour:
- Reset: queue emptied; state IDLE; all outputs 0, including PULSE_CNT. RESET overrides every other input in the same cycle.
- Queue: FIFO of {start, N, type, Ti, Tp, Tb1, Tb2}.
  - WR_DATA while CMD_FULL: write dropped, queue unchanged.
  - Simultaneous push and pop while full: both succeed.
- States: IDLE, WAIT, BLANK1, IZ, BLANK2, PR.
- IDLE:
  - Queue non-empty: pop the head into working registers and go to WAIT.
  - Popped N==0: command discarded and REQ_COMMAND pulses; stay in IDLE.
- WAIT:
  - First WAIT cycle with TIME > start: LATE=1 for that cycle; command discarded; REQ_COMMAND pulses; back to IDLE.
  - Cycle where TIME == start: move to the first phase with non-zero length. The first output is asserted on the following cycle, i.e. one cycle after TIME == start.
- Phase lengths: each phase lasts exactly its programmed value in cycles. A down-counter is loaded with length-1. A zero-length phase is skipped with no idle cycle.
- Windows: En_Iz is 1 exactly during IZ; En_Pr is 1 exactly during PR; both are registered outputs.
- DDS_start (1 cycle, on the first cycle of IZ):
  - Type bit0=0: asserted on every pulse period.
  - Type bit0=1: asserted on pulse 0 only.
  - Ti==0: no DDS_start for that period.
- End of PR (or the last non-zero phase):
  - PULSE_CNT < N-1: increment PULSE_CNT and go to the first non-zero phase.
  - Otherwise: REQ_COMMAND=1 for one cycle, PULSE_CNT cleared, go to IDLE. A queued next command may enter WAIT on the following cycle.
- All four lengths zero with N>0: burst completes on the cycle after the start match; REQ_COMMAND pulses; no windows asserted.
- ABORT (any state):
  - Next cycle: IDLE, queue flushed, En_Iz, En_Pr, BUSY and PULSE_CNT cleared; no REQ_COMMAND.
  - ABORT with WR_DATA in the same cycle: the write is discarded.
- Arithmetic: TIME compare is unsigned full width. Durations are unsigned; the maximum value 2^CNT_W-1 is supported. TIME wrap is not handled; a wrapped start time is treated as late.

Decomposition:
- Package burst_seq_pkg:
  - state enum
  - cmd_t packed struct parametrised by widths through package localparams matching the defaults
  - TYPE_COHERENT bit index constant
- One sub-module cmd_fifo: synchronous FIFO, width = $bits(cmd_t), depth CMD_DEPTH, with full/empty flags and push/pop/flush.

Test Plan:
- Basic emit/receive train:
  - Stimulus: reset, then push start=0x12C0, N=2, type=1, Ti=Tp=0x1800, Tb1=Tb2=0x180; TIME counts from 0.
  - En_Iz first high at TIME=0x12C0+1+0x180 for 0x1800 cycles; En_Pr high 0x1800 cycles after a 0x180 gap.
  - Two periods in total; exactly one DDS_start; REQ_COMMAND pulses once after the second PR.
- Non-coherent mode: same command with type=0, N=3 -> three DDS_start pulses, each on the first IZ cycle; PULSE_CNT steps 0,1,2 then returns to 0.
- Late command: TIME=0x2000, push start=0x1000 -> LATE pulses once, no windows asserted, REQ_COMMAND pulses.
- Zero-length phases:
  - Tb1=0, Tb2=0, Ti=4, Tp=3, N=2 -> pattern Iz×4, Pr×3, Iz×4, Pr×3 with no gaps.
  - N=0 -> command discarded, REQ_COMMAND pulses.
- Queue full and back-to-back:
  - Push 5 commands with CMD_DEPTH=4 -> CMD_FULL after the 4th write; the 5th write is dropped.
  - The queued commands execute in order, each entering WAIT one cycle after the previous REQ_COMMAND.
- Abort:
  - ABORT mid-IZ with 2 commands queued -> next cycle En_Iz=0 and BUSY=0, queue empty, no further windows, no REQ_COMMAND.
  - RESET mid-PR -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/burst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : burst_seq_pkg
// Purpose  : Shared state encoding, command record and phase helpers for the
//            burst sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package burst_seq_pkg;

  localparam int c_TIME_W        = 64;
  localparam int c_CNT_W         = 32;
  localparam int c_NP_W          = 16;
  localparam int c_CMD_DEPTH     = 4;
  localparam int c_TYPE_COHERENT = 0;

  // Phase states are numbered in the order they occur inside one pulse period.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_BLANK1 = 3'd2,
    S_IZ     = 3'd3,
    S_BLANK2 = 3'd4,
    S_PR     = 3'd5
  } state_t;

  typedef struct packed {
    logic [c_TIME_W-1:0] start;
    logic [c_NP_W-1:0]   n;
    logic [1:0]          kind;
    logic [c_CNT_W-1:0]  ti;
    logic [c_CNT_W-1:0]  tp;
    logic [c_CNT_W-1:0]  tb1;
    logic [c_CNT_W-1:0]  tb2;
  } cmd_t;

  function automatic logic [c_CNT_W-1:0] phase_len(state_t ph, cmd_t cmd);
    logic [c_CNT_W-1:0] len;
    len = '0;
    case (ph)
      S_BLANK1: len = cmd.tb1;
      S_IZ:     len = cmd.ti;
      S_BLANK2: len = cmd.tb2;
      S_PR:     len = cmd.tp;
      default:  len = '0;
    endcase
    return len;
  endfunction

  // First non-empty phase strictly after 'from'; S_IDLE when the period is exhausted.
  function automatic state_t next_phase(state_t from, cmd_t cmd);
    state_t ph;
    ph = S_IDLE;
    if (from < S_PR     && cmd.tp  != '0) ph = S_PR;
    if (from < S_BLANK2 && cmd.tb2 != '0) ph = S_BLANK2;
    if (from < S_IZ     && cmd.ti  != '0) ph = S_IZ;
    if (from < S_BLANK1 && cmd.tb1 != '0) ph = S_BLANK1;
    return ph;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Purpose  : Synchronous first-word-fall-through FIFO with flush; a push into
//            a full FIFO succeeds only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = r_count[c_PTR_W];
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (c_PTR_W+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (c_PTR_W+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : burst_sequencer
// Purpose  : Queues timed radar commands and plays N periods of the
//            blank1 / emit / blank2 / receive train with DDS start strobes.
// Revision : 1.0 - initial release
// ============================================================================
module burst_sequencer
  import burst_seq_pkg::*;
#(
  parameter int TIME_W    = c_TIME_W,
  parameter int CNT_W     = c_CNT_W,
  parameter int NP_W      = c_NP_W,
  parameter int CMD_DEPTH = c_CMD_DEPTH
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [TIME_W-1:0] TIME,
  input  logic              WR_DATA,
  input  logic [TIME_W-1:0] MEM_TIME_START,
  input  logic [NP_W-1:0]   MEM_N_impuls,
  input  logic [1:0]        MEM_TYPE_impulse,
  input  logic [CNT_W-1:0]  MEM_Interval_Ti,
  input  logic [CNT_W-1:0]  MEM_Interval_Tp,
  input  logic [CNT_W-1:0]  MEM_Tblank1,
  input  logic [CNT_W-1:0]  MEM_Tblank2,
  input  logic              ABORT,
  output logic              REQ_COMMAND,
  output logic              DDS_start,
  output logic              En_Iz,
  output logic              En_Pr,
  output logic              BUSY,
  output logic              LATE,
  output logic              CMD_FULL,
  output logic [NP_W-1:0]   PULSE_CNT
);

  cmd_t             w_push_cmd;
  cmd_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  state_t           r_state;
  cmd_t             r_cmd;
  logic [CNT_W-1:0] r_cnt;
  logic [NP_W-1:0]  r_pulse;
  logic             r_req;
  logic             r_dds;
  logic             r_iz;
  logic             r_pr;
  logic             r_busy;
  logic             r_late;

  state_t           w_first_ph;
  state_t           w_succ_ph;
  state_t           w_enter_ph;
  logic [NP_W-1:0]  w_enter_pulse;
  logic [CNT_W-1:0] w_enter_len;
  logic             w_finish;
  logic             w_unused;

  always_comb begin
    w_push_cmd       = '0;
    w_push_cmd.start = MEM_TIME_START;
    w_push_cmd.n     = MEM_N_impuls;
    w_push_cmd.kind  = MEM_TYPE_impulse;
    w_push_cmd.ti    = MEM_Interval_Ti;
    w_push_cmd.tp    = MEM_Interval_Tp;
    w_push_cmd.tb1   = MEM_Tblank1;
    w_push_cmd.tb2   = MEM_Tblank2;
  end

  assign w_pop    = (r_state == S_IDLE) && !w_empty;
  assign w_unused = r_cmd.kind[1];

  cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .i_push    (WR_DATA),
    .i_pop     (w_pop),
    .i_flush   (ABORT),
    .i_wr_data (w_push_cmd),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Decide which phase (if any) starts next cycle, so its window can be registered now.
  always_comb begin
    w_first_ph    = next_phase(S_WAIT, r_cmd);
    w_succ_ph     = next_phase(r_state, r_cmd);
    w_enter_ph    = S_IDLE;
    w_enter_pulse = r_pulse;
    w_finish      = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (TIME == r_cmd.start) begin
          w_enter_pulse = '0;
          if (w_first_ph == S_IDLE) w_finish = 1'b1;
          else                      w_enter_ph = w_first_ph;
        end
      end
      S_BLANK1, S_IZ, S_BLANK2, S_PR: begin
        if (r_cnt == '0) begin
          if (w_succ_ph != S_IDLE) begin
            w_enter_ph = w_succ_ph;
          end else if (r_pulse < r_cmd.n - NP_W'(1)) begin
            w_enter_ph    = w_first_ph;
            w_enter_pulse = r_pulse + NP_W'(1);
          end else begin
            w_finish = 1'b1;
          end
        end
      end
      default: ;
    endcase
    w_enter_len = phase_len(w_enter_ph, r_cmd);
  end

  always_ff @(posedge CLK) begin
    if (RESET || ABORT) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pulse <= '0;
      r_req   <= 1'b0;
      r_dds   <= 1'b0;
      r_iz    <= 1'b0;
      r_pr    <= 1'b0;
      r_busy  <= 1'b0;
      r_late  <= 1'b0;
    end else begin
      r_req  <= 1'b0;
      r_dds  <= 1'b0;
      r_late <= 1'b0;
      if (w_enter_ph != S_IDLE) begin
        r_state <= w_enter_ph;
        r_cnt   <= w_enter_len - CNT_W'(1);
        r_pulse <= w_enter_pulse;
        r_iz    <= (w_enter_ph == S_IZ);
        r_pr    <= (w_enter_ph == S_PR);
        r_busy  <= 1'b1;
        r_dds   <= (w_enter_ph == S_IZ) &&
                   (!r_cmd.kind[c_TYPE_COHERENT] || (w_enter_pulse == '0));
      end else if (w_finish) begin
        r_state <= S_IDLE;
        r_pulse <= '0;
        r_iz    <= 1'b0;
        r_pr    <= 1'b0;
        r_busy  <= 1'b0;
        r_req   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_empty) begin
              r_cmd <= w_head;
              if (w_head.n == '0) r_req   <= 1'b1;
              else                r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (TIME > r_cmd.start) begin
              r_late  <= 1'b1;
              r_req   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_cnt <= r_cnt - CNT_W'(1);
        endcase
      end
    end
  end

  assign REQ_COMMAND = r_req;
  assign DDS_start   = r_dds;
  assign En_Iz       = r_iz;
  assign En_Pr       = r_pr;
  assign BUSY        = r_busy;
  assign LATE        = r_late;
  assign CMD_FULL    = w_full;
  assign PULSE_CNT   = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_sequencer
// Purpose  : Directed and randomized bench for burst_sequencer against a
//            timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_sequencer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [63:0] TIME;
  logic        WR_DATA;
  logic [63:0] MEM_TIME_START;
  logic [15:0] MEM_N_impuls;
  logic [1:0]  MEM_TYPE_impulse;
  logic [31:0] MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2;
  logic        ABORT;
  logic        REQ_COMMAND, DDS_start, En_Iz, En_Pr, BUSY, LATE, CMD_FULL;
  logic [15:0] PULSE_CNT;

  always #5 CLK = ~CLK;

  burst_sequencer dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .TIME             (TIME),
    .WR_DATA          (WR_DATA),
    .MEM_TIME_START   (MEM_TIME_START),
    .MEM_N_impuls     (MEM_N_impuls),
    .MEM_TYPE_impulse (MEM_TYPE_impulse),
    .MEM_Interval_Ti  (MEM_Interval_Ti),
    .MEM_Interval_Tp  (MEM_Interval_Tp),
    .MEM_Tblank1      (MEM_Tblank1),
    .MEM_Tblank2      (MEM_Tblank2),
    .ABORT            (ABORT),
    .REQ_COMMAND      (REQ_COMMAND),
    .DDS_start        (DDS_start),
    .En_Iz            (En_Iz),
    .En_Pr            (En_Pr),
    .BUSY             (BUSY),
    .LATE             (LATE),
    .CMD_FULL         (CMD_FULL),
    .PULSE_CNT        (PULSE_CNT)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (TIME=0x%0h)", tag, obs, exp, TIME);
    end
  endtask

  // Reference model: a running burst is described only by its origin cycle;
  // every window follows from the offset into the N*P cycle timeline.
  typedef struct {
    logic [63:0]     start;
    longint unsigned n;
    bit              coh;
    longint unsigned ti, tp, tb1, tb2;
  } mcmd_t;

  mcmd_t           mq[$];
  mcmd_t           cur;
  int              mode = 0;  // 0 idle, 1 waiting for start, 2 running
  longint unsigned cyc = 0;
  longint unsigned s0 = 0;
  bit              e_req, e_late, e_iz, e_pr, e_dds, e_busy, e_full;
  longint unsigned e_pc;

  function automatic longint unsigned period(input mcmd_t c);
    return c.tb1 + c.ti + c.tb2 + c.tp;
  endfunction

  task automatic model_step();
    mcmd_t nc;
    e_req  = 0;
    e_late = 0;
    if (RESET || ABORT) begin
      mq.delete();
      mode = 0;
    end else begin
      case (mode)
        0: if (mq.size() > 0) begin
             cur = mq.pop_front();
             if (cur.n == 0) e_req = 1;
             else            mode  = 1;
           end
        1: if (TIME > cur.start) begin
             e_late = 1; e_req = 1; mode = 0;
           end else if (TIME == cur.start) begin
             if (period(cur) == 0) begin e_req = 1; mode = 0; end
             else begin mode = 2; s0 = cyc + 1; end
           end
        default: if (cyc + 1 - s0 >= cur.n * period(cur)) begin
             e_req = 1; mode = 0;
           end
      endcase
      if (WR_DATA && mq.size() < DEPTH) begin
        nc.start = MEM_TIME_START;
        nc.n     = longint'(MEM_N_impuls);
        nc.coh   = MEM_TYPE_impulse[0];
        nc.ti    = longint'(MEM_Interval_Ti);
        nc.tp    = longint'(MEM_Interval_Tp);
        nc.tb1   = longint'(MEM_Tblank1);
        nc.tb2   = longint'(MEM_Tblank2);
        mq.push_back(nc);
      end
    end
    cyc++;
    e_iz = 0; e_pr = 0; e_dds = 0; e_busy = 0; e_pc = 0;
    if (mode == 2) begin
      longint unsigned o, p, w, per;
      per = period(cur);
      o = cyc - s0;
      p = o / per;
      w = o % per;
      e_iz   = (w >= cur.tb1) && (w < cur.tb1 + cur.ti);
      e_pr   = (w >= cur.tb1 + cur.ti + cur.tb2);
      e_dds  = (w == cur.tb1) && (cur.ti != 0) && (!cur.coh || p == 0);
      e_busy = 1;
      e_pc   = p;
    end
    e_full = (mq.size() == DEPTH);
  endtask

  int          n_dds, n_req, n_late, n_iz, n_pr;
  logic [63:0] first_iz;
  logic [15:0] dds_pc[$];

  task automatic clear_stats();
    n_dds = 0; n_req = 0; n_late = 0; n_iz = 0; n_pr = 0; first_iz = '0;
    dds_pc.delete();
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    TIME    = TIME + 64'd1;
    WR_DATA = 1'b0;
    ABORT   = 1'b0;
    RESET   = 1'b0;
    check("REQ_COMMAND", REQ_COMMAND, e_req);
    check("LATE",        LATE,        e_late);
    check("DDS_start",   DDS_start,   e_dds);
    check("En_Iz",       En_Iz,       e_iz);
    check("En_Pr",       En_Pr,       e_pr);
    check("BUSY",        BUSY,        e_busy);
    check("CMD_FULL",    CMD_FULL,    e_full);
    check("PULSE_CNT",   PULSE_CNT,   e_pc);
    if (DDS_start) begin n_dds++; dds_pc.push_back(PULSE_CNT); end
    if (REQ_COMMAND) n_req++;
    if (LATE) n_late++;
    if (En_Pr) n_pr++;
    if (En_Iz) begin
      if (n_iz == 0) first_iz = TIME;
      n_iz++;
    end
  endtask

  task automatic push(input logic [63:0] st, input int n, input int ty,
                      input int ti, input int tp, input int tb1, input int tb2);
    WR_DATA          = 1'b1;
    MEM_TIME_START   = st;
    MEM_N_impuls     = 16'(n);
    MEM_TYPE_impulse = 2'(ty);
    MEM_Interval_Ti  = 32'(ti);
    MEM_Interval_Tp  = 32'(tp);
    MEM_Tblank1      = 32'(tb1);
    MEM_Tblank2      = 32'(tb2);
    tick();
  endtask

  task automatic run_until_reqs(input int want, input int bound, input string tag);
    int k = 0;
    while (n_req < want && k < bound) begin
      tick();
      k++;
    end
    check(tag, 64'(k < bound), 64'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; ABORT = 1'b0; WR_DATA = 1'b0; TIME = '0;
    MEM_TIME_START = '0; MEM_N_impuls = '0; MEM_TYPE_impulse = '0;
    MEM_Interval_Ti = '0; MEM_Interval_Tp = '0; MEM_Tblank1 = '0; MEM_Tblank2 = '0;
    tick();
    check("reset_busy",  BUSY, 1'b0);
    check("reset_pulse", PULSE_CNT, 16'd0);

    // Basic coherent train, TIME counting from 0
    TIME = '0;
    clear_stats();
    push(64'h12C0, 2, 1, 'h1800, 'h1800, 'h180, 'h180);
    run_until_reqs(1, 40000, "basic_timeout");
    check("basic_first_iz", first_iz, 64'h12C0 + 64'd1 + 64'h180);
    check("basic_dds",      n_dds, 1);
    check("basic_req",      n_req, 1);
    check("basic_iz_len",   n_iz, 2 * 'h1800);
    check("basic_pr_len",   n_pr, 2 * 'h1800);

    // Per-pulse restart, three periods
    clear_stats();
    push(TIME + 64'd20, 3, 0, 'h1800, 'h1800, 'h180, 'h180);
    run_until_reqs(1, 45000, "noncoh_timeout");
    check("noncoh_dds", n_dds, 3);
    for (int i = 0; i < dds_pc.size(); i++) check("noncoh_pc", dds_pc[i], 64'(i));
    check("noncoh_pc_end", PULSE_CNT, 16'd0);

    // Late command
    TIME = 64'h2000;
    clear_stats();
    push(64'h1000, 1, 0, 4, 4, 1, 1);
    run_until_reqs(1, 10, "late_timeout");
    check("late_flag", n_late, 1);
    check("late_win",  n_iz + n_pr, 0);

    // Zero-length blanks, then N=0
    clear_stats();
    push(TIME + 64'd5, 2, 0, 4, 3, 0, 0);
    run_until_reqs(1, 40, "zero_timeout");
    check("zero_iz",  n_iz, 8);
    check("zero_pr",  n_pr, 6);
    check("zero_dds", n_dds, 2);
    clear_stats();
    push(TIME + 64'd5, 0, 0, 4, 3, 1, 1);
    run_until_reqs(1, 10, "n0_timeout");
    check("n0_late", n_late, 0);
    check("n0_win",  n_iz + n_pr, 0);

    // Queue fill with one command already waiting
    clear_stats();
    push(TIME + 64'd100, 1, 0, 2, 2, 2, 2);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      push(TIME + 64'd200 + 64'(i * 30), 2, 1, 2, 2, 2, 2);
      if (i == 3) check("full_after_4", CMD_FULL, 1'b1);
    end
    run_until_reqs(5, 1000, "queue_timeout");
    repeat (200) tick();
    check("queue_reqs", n_req, 5);
    check("queue_late", n_late, 0);

    // Abort mid-emit with two queued commands
    clear_stats();
    push(TIME + 64'd10, 3, 0, 20, 5, 5, 5);
    push(TIME + 64'd300, 1, 0, 3, 3, 3, 3);
    push(TIME + 64'd400, 1, 0, 3, 3, 3, 3);
    begin
      int k = 0;
      while (!En_Iz && k < 100) begin tick(); k++; end
      check("abort_wait_iz", 64'(k < 100), 64'd1);
    end
    repeat (3) tick();
    ABORT = 1'b1;
    tick();
    check("abort_iz",   En_Iz, 1'b0);
    check("abort_busy", BUSY, 1'b0);
    clear_stats();
    repeat (600) tick();
    check("abort_quiet", n_iz + n_pr + n_req, 0);

    // Reset mid-receive
    push(TIME + 64'd5, 1, 0, 3, 3, 3, 3);
    begin
      int k = 0;
      while (!En_Pr && k < 100) begin tick(); k++; end
      check("rst_wait_pr", 64'(k < 100), 64'd1);
    end
    RESET = 1'b1;
    tick();
    check("rst_pr",   En_Pr, 1'b0);
    check("rst_busy", BUSY, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 15) begin
        WR_DATA = 1'b1;
        if ($urandom_range(0, 9) == 0) MEM_TIME_START = TIME - 64'($urandom_range(0, 5));
        else                           MEM_TIME_START = TIME + 64'($urandom_range(0, 30));
        MEM_N_impuls     = 16'($urandom_range(0, 3));
        MEM_TYPE_impulse = 2'($urandom_range(0, 3));
        MEM_Interval_Ti  = 32'($urandom_range(0, 4));
        MEM_Interval_Tp  = 32'($urandom_range(0, 4));
        MEM_Tblank1      = 32'($urandom_range(0, 4));
        MEM_Tblank2      = 32'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 199) < 2) ABORT = 1'b1;
      if ($urandom_range(0, 399) < 1) RESET = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
